// File: rtl/move_controller.sv
// Gomoku move-entry controller: cursor, place/read/write handshake, win-check hand-off, turn/game tracking.
// Optional feature macro: CURSOR_WRAP_EN (cursor wraps at board edges instead of saturating).
module move_controller #(
  parameter int N  = 15,
  parameter int CW = 4
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          btn_left,
  input  logic          btn_right,
  input  logic          btn_up,
  input  logic          btn_down,
  input  logic          btn_place,
  output logic [CW-1:0] cursor_x,
  output logic [CW-1:0] cursor_y,
  input  logic [1:0]    rd_data,
  output logic          wr_en,
  output logic [CW-1:0] wr_x,
  output logic [CW-1:0] wr_y,
  output logic [1:0]    wr_data,
  output logic          turn,
  output logic          illegal,
  output logic          check_req,
  input  logic          check_done,
  input  logic          check_win,
  output logic [7:0]    move_count,
  output logic          game_over,
  output logic [1:0]    winner
);

  localparam logic [CW-1:0] MAXC   = CW'(N - 1);
  localparam logic [CW-1:0] CENTER = CW'(N / 2);
  localparam logic [7:0]    CELLS  = 8'(N * N);

  typedef enum logic [2:0] {IDLE, READ, WRITE, CHECK, OVER} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cursor_x_q, cursor_x_d, cursor_y_q, cursor_y_d;
  logic [CW-1:0] wr_x_q, wr_x_d, wr_y_q, wr_y_d;
  logic          wr_en_q, wr_en_d, illegal_q, illegal_d;
  logic          check_req_q, check_req_d, turn_q, turn_d;
  logic          game_over_q, game_over_d;
  logic [1:0]    wr_data_q, wr_data_d, winner_q, winner_d;
  logic [7:0]    move_count_q, move_count_d;

  // One axis step: opposite buttons together cancel out.
  function automatic logic [CW-1:0] step_axis(input logic [CW-1:0] p,
                                              input logic dec, input logic inc);
    logic [CW-1:0] r;
    r = p;
    if (dec && !inc) begin
`ifdef CURSOR_WRAP_EN
      r = (p == '0) ? MAXC : p - CW'(1);
`else
      r = (p == '0) ? p : p - CW'(1);
`endif
    end else if (inc && !dec) begin
`ifdef CURSOR_WRAP_EN
      r = (p == MAXC) ? '0 : p + CW'(1);
`else
      r = (p == MAXC) ? p : p + CW'(1);
`endif
    end
    return r;
  endfunction

  always_comb begin
    state_d      = state_q;
    cursor_x_d   = cursor_x_q;
    cursor_y_d   = cursor_y_q;
    wr_x_d       = wr_x_q;
    wr_y_d       = wr_y_q;
    wr_en_d      = 1'b0;
    wr_data_d    = 2'b00;
    illegal_d    = 1'b0;
    check_req_d  = check_req_q;
    turn_d       = turn_q;
    game_over_d  = game_over_q;
    winner_d     = winner_q;
    move_count_d = move_count_q;
    case (state_q)
      IDLE: begin
        if (btn_place) begin
          wr_x_d  = cursor_x_q;
          wr_y_d  = cursor_y_q;
          state_d = READ;
        end else begin
          cursor_x_d = step_axis(cursor_x_q, btn_left, btn_right);
          cursor_y_d = step_axis(cursor_y_q, btn_up, btn_down);
        end
      end
      READ: begin
        // Cursor is frozen here, so rd_data reflects (wr_x, wr_y).
        if (rd_data != 2'b00) begin
          illegal_d = 1'b1;
          state_d   = IDLE;
        end else begin
          wr_en_d   = 1'b1;
          wr_data_d = turn_q ? 2'b10 : 2'b01;
          state_d   = WRITE;
        end
      end
      WRITE: begin
        move_count_d = (move_count_q == CELLS) ? CELLS : move_count_q + 8'd1;
        check_req_d  = 1'b1;
        state_d      = CHECK;
      end
      CHECK: begin
        if (check_done) begin
          check_req_d = 1'b0;
          if (check_win) begin
            game_over_d = 1'b1;
            winner_d    = turn_q ? 2'b10 : 2'b01;
            state_d     = OVER;
          end else if (move_count_q == CELLS) begin
            game_over_d = 1'b1;
            winner_d    = 2'b00;
            state_d     = OVER;
          end else begin
            turn_d  = ~turn_q;
            state_d = IDLE;
          end
        end
      end
      OVER:    ;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      cursor_x_q   <= CENTER;
      cursor_y_q   <= CENTER;
      wr_x_q       <= '0;
      wr_y_q       <= '0;
      wr_en_q      <= 1'b0;
      wr_data_q    <= 2'b00;
      illegal_q    <= 1'b0;
      check_req_q  <= 1'b0;
      turn_q       <= 1'b1;
      game_over_q  <= 1'b0;
      winner_q     <= 2'b00;
      move_count_q <= 8'd0;
    end else begin
      state_q      <= state_d;
      cursor_x_q   <= cursor_x_d;
      cursor_y_q   <= cursor_y_d;
      wr_x_q       <= wr_x_d;
      wr_y_q       <= wr_y_d;
      wr_en_q      <= wr_en_d;
      wr_data_q    <= wr_data_d;
      illegal_q    <= illegal_d;
      check_req_q  <= check_req_d;
      turn_q       <= turn_d;
      game_over_q  <= game_over_d;
      winner_q     <= winner_d;
      move_count_q <= move_count_d;
    end
  end

  assign cursor_x   = cursor_x_q;
  assign cursor_y   = cursor_y_q;
  assign wr_en      = wr_en_q;
  assign wr_x       = wr_x_q;
  assign wr_y       = wr_y_q;
  assign wr_data    = wr_data_q;
  assign turn       = turn_q;
  assign illegal    = illegal_q;
  assign check_req  = check_req_q;
  assign move_count = move_count_q;
  assign game_over  = game_over_q;
  assign winner     = winner_q;

endmodule

// File: tb/tb_move_controller.sv
// Bench for move_controller: a 15x15 instance for cursor/place/win behaviour and a 5x5 instance for the draw.
module tb_move_controller;
  localparam int N  = 15;
  localparam int N5 = 5;
`ifdef CURSOR_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       rst15, rst5, bl, br, bu, bd, bp, cdone, cwin;
  logic [3:0] cx15, cy15, wx15, wy15;
  logic [2:0] cx5, cy5, wx5, wy5;
  logic [1:0] rd15, rd5, wd15, wd5, win15, win5;
  logic       we15, we5, turn15, turn5, ill15, ill5, req15, req5, go15, go5;
  logic [7:0] mc15, mc5;

  logic [1:0] board15 [N*N];
  logic [1:0] board5  [N5*N5];

  always_comb begin
    rd15 = 2'b00;
    if (int'(cy15) * N + int'(cx15) < N * N) rd15 = board15[int'(cy15) * N + int'(cx15)];
  end
  always_comb begin
    rd5 = 2'b00;
    if (int'(cy5) * N5 + int'(cx5) < N5 * N5) rd5 = board5[int'(cy5) * N5 + int'(cx5)];
  end

  move_controller #(.N(N), .CW(4)) dut15 (
    .clock(clock), .reset(rst15), .btn_left(bl), .btn_right(br), .btn_up(bu), .btn_down(bd),
    .btn_place(bp), .cursor_x(cx15), .cursor_y(cy15), .rd_data(rd15), .wr_en(we15),
    .wr_x(wx15), .wr_y(wy15), .wr_data(wd15), .turn(turn15), .illegal(ill15),
    .check_req(req15), .check_done(cdone), .check_win(cwin), .move_count(mc15),
    .game_over(go15), .winner(win15));

  move_controller #(.N(N5), .CW(3)) dut5 (
    .clock(clock), .reset(rst5), .btn_left(bl), .btn_right(br), .btn_up(bu), .btn_down(bd),
    .btn_place(bp), .cursor_x(cx5), .cursor_y(cy5), .rd_data(rd5), .wr_en(we5),
    .wr_x(wx5), .wr_y(wy5), .wr_data(wd5), .turn(turn5), .illegal(ill5),
    .check_req(req5), .check_done(cdone), .check_win(cwin), .move_count(mc5),
    .game_over(go5), .winner(win5));

  int n_pass = 0, n_total = 0;
  // Reference game state for the 15x15 instance.
  int mx, my, mturn, mcount, mwin;
  bit mover;

  typedef struct {bit l, r, u, d; int ex, ey;} vec_t;
  vec_t tbl[12];

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_btn();
    bl = 0; br = 0; bu = 0; bd = 0; bp = 0;
  endtask

  function automatic int mv(input int p, input bit dec, input bit inc, input int n);
    int r;
    r = p;
    if (dec && !inc) r = p - 1;
    else if (inc && !dec) r = p + 1;
    if (WRAP) begin
      if (r < 0) r = n - 1;
      if (r >= n) r = 0;
    end else begin
      if (r < 0) r = 0;
      if (r >= n) r = n - 1;
    end
    return r;
  endfunction

  task automatic check_reset15();
    chk("rst_cursor_x", cx15, N / 2);  chk("rst_cursor_y", cy15, N / 2);
    chk("rst_wr_x", wx15, 0);          chk("rst_wr_y", wy15, 0);
    chk("rst_turn", turn15, 1);        chk("rst_wr_en", we15, 0);
    chk("rst_wr_data", wd15, 0);       chk("rst_illegal", ill15, 0);
    chk("rst_check_req", req15, 0);    chk("rst_game_over", go15, 0);
    chk("rst_winner", win15, 0);       chk("rst_move_count", mc15, 0);
  endtask

  task automatic do_reset15();
    rst15 = 1; tick(); rst15 = 0;
    mx = N / 2; my = N / 2; mturn = 1; mcount = 0; mover = 0; mwin = 0;
    foreach (board15[i]) board15[i] = 2'b00;
  endtask

  task automatic move15(input bit l, input bit r, input bit u, input bit d);
    bl = l; br = r; bu = u; bd = d;
    tick();
    clear_btn();
    if (!mover) begin
      mx = mv(mx, l, r, N);
      my = mv(my, u, d, N);
    end
    chk("cursor_x", cx15, mx);
    chk("cursor_y", cy15, my);
  endtask

  // Full place transaction on the 15x15 instance; also pokes a button in READ to confirm it is dropped.
  task automatic place15(input int delay, input bit win, input bit extra);
    int col;
    bp = 1; bu = extra; br = extra;
    tick();
    clear_btn();
    chk("read_cursor_x", cx15, mx); chk("read_cursor_y", cy15, my);
    br = 1;
    tick();
    br = 0;
    col = mturn ? 2 : 1;
    if (board15[my * N + mx] != 2'b00) begin
      chk("illegal_pulse", ill15, 1); chk("illegal_no_wr", we15, 0);
      tick();
      chk("illegal_clear", ill15, 0); chk("illegal_turn", turn15, mturn);
      chk("illegal_count", mc15, mcount); chk("illegal_cursor_x", cx15, mx);
      chk("illegal_req", req15, 0);
      return;
    end
    chk("wr_en", we15, 1); chk("wr_x", wx15, mx); chk("wr_y", wy15, my);
    chk("wr_data", wd15, col); chk("no_illegal", ill15, 0);
    board15[my * N + mx] = 2'(col);
    mcount++;
    tick();
    chk("wr_en_single", we15, 0); chk("check_req_on", req15, 1);
    chk("move_count", mc15, mcount); chk("check_cursor_x", cx15, mx);
    for (int i = 0; i < delay; i++) begin
      tick();
      chk("check_req_hold", req15, 1);
    end
    cdone = 1; cwin = win;
    tick();
    cdone = 0; cwin = 0;
    chk("check_req_drop", req15, 0);
    if (win) begin
      mover = 1; mwin = col;
    end else if (mcount == N * N) begin
      mover = 1; mwin = 0;
    end else begin
      mturn = 1 - mturn;
    end
    chk("turn", turn15, mturn); chk("game_over", go15, int'(mover));
    chk("winner", win15, mwin);
  endtask

  task automatic over_test();
    for (int i = 0; i < 4; i++) begin
      bl = 1'($urandom_range(0, 1)); br = 1'($urandom_range(0, 1));
      bu = 1'($urandom_range(0, 1)); bd = 1'($urandom_range(0, 1));
      bp = 1'(i & 1);
      tick();
      clear_btn();
      chk("over_cursor_x", cx15, mx); chk("over_cursor_y", cy15, my);
      chk("over_wr_en", we15, 0); chk("over_game_over", go15, 1);
      chk("over_winner", win15, mwin);
    end
  endtask

  initial begin
    int m5x, m5y, tx, ty, k;
    rst15 = 1; rst5 = 1; cdone = 0; cwin = 0;
    clear_btn();
    tbl[0]  = '{0, 1, 0, 0, 8, 7};
    tbl[1]  = '{0, 1, 0, 0, 9, 7};
    tbl[2]  = '{0, 1, 0, 0, 10, 7};
    tbl[3]  = '{0, 1, 0, 0, 11, 7};
    tbl[4]  = '{0, 1, 0, 0, 12, 7};
    tbl[5]  = '{0, 1, 0, 0, 13, 7};
    tbl[6]  = '{0, 1, 0, 0, 14, 7};
    tbl[7]  = '{0, 1, 0, 0, WRAP ? 0 : 14, 7};
    tbl[8]  = '{1, 1, 0, 0, WRAP ? 0 : 14, 7};
    tbl[9]  = '{1, 0, 1, 0, WRAP ? 14 : 13, 6};
    tbl[10] = '{0, 0, 1, 1, WRAP ? 14 : 13, 6};
    tbl[11] = '{0, 1, 0, 1, WRAP ? 0 : 14, 7};

    do_reset15();
    check_reset15();

    foreach (tbl[i]) begin
      bl = tbl[i].l; br = tbl[i].r; bu = tbl[i].u; bd = tbl[i].d;
      tick();
      clear_btn();
      chk("tbl_cursor_x", cx15, tbl[i].ex);
      chk("tbl_cursor_y", cy15, tbl[i].ey);
    end

    // Legal place at the centre, then an occupied (white) cell, then place with up held.
    do_reset15();
    place15(0, 0, 0);
    move15(0, 1, 0, 0);
    board15[my * N + mx] = 2'b01;
    place15(0, 0, 0);
    move15(0, 0, 0, 1);
    place15(1, 0, 1);

    // check_done outside CHECK must not end the game.
    cdone = 1; cwin = 1;
    tick();
    cdone = 0; cwin = 0;
    chk("stray_done_over", go15, 0); chk("stray_done_turn", turn15, mturn);

    // Reset landing on the edge that would enter WRITE.
    move15(1, 0, 0, 0);
    bp = 1; tick(); clear_btn();
    rst15 = 1; tick(); rst15 = 0;
    chk("rst_write_wr_en", we15, 0);
    check_reset15();
    do_reset15();

    // Black wins on the first move.
    place15(2, 1, 0);
    over_test();
    do_reset15();

    // Randomized play against the reference game state.
    for (int it = 0; it < 300; it++) begin
      if ($urandom_range(0, 9) < 7) begin
        bit l, r, u, d;
        int reps;
        l = 1'($urandom_range(0, 1)); r = 1'($urandom_range(0, 1));
        u = 1'($urandom_range(0, 1)); d = 1'($urandom_range(0, 1));
        reps = ($urandom_range(0, 3) == 0) ? 16 : 1;
        for (int j = 0; j < reps; j++) move15(l, r, u, d);
      end else begin
        place15($urandom_range(0, 3), $urandom_range(0, 29) == 0, 1'($urandom_range(0, 1)));
        if (mover) begin
          over_test();
          do_reset15();
          check_reset15();
        end
      end
    end

    // Draw on the 5x5 board: fill all 25 cells without a win.
    rst15 = 1;
    rst5 = 1; tick(); rst5 = 0;
    foreach (board5[i]) board5[i] = 2'b00;
    chk("n5_rst_cursor_x", cx5, 2); chk("n5_rst_cursor_y", cy5, 2);
    m5x = 2; m5y = 2;
    for (k = 0; k < N5 * N5; k++) begin
      tx = k % N5; ty = k / N5;
      for (int s = 0; s < 8 && (m5x != tx || m5y != ty); s++) begin
        bl = (m5x > tx); br = (m5x < tx); bu = (m5y > ty); bd = (m5y < ty);
        tick();
        if (bl) m5x--; else if (br) m5x++;
        if (bu) m5y--; else if (bd) m5y++;
        clear_btn();
      end
      chk("n5_cursor_x", cx5, tx); chk("n5_cursor_y", cy5, ty);
      bp = 1; tick(); clear_btn();
      tick();
      chk("n5_wr_en", we5, 1);
      chk("n5_wr_data", wd5, (k % 2 == 0) ? 2 : 1);
      board5[ty * N5 + tx] = (k % 2 == 0) ? 2'b10 : 2'b01;
      tick();
      cdone = 1; cwin = 0;
      tick();
      cdone = 0;
      if (k < N5 * N5 - 1) chk("n5_not_over", go5, 0);
    end
    chk("n5_game_over", go5, 1);
    chk("n5_winner", win5, 0);
    chk("n5_move_count", mc5, 25);
    bp = 1; tick(); tick(); tick(); clear_btn();
    chk("n5_over_no_wr", we5, 0);
    chk("n5_over_count", mc5, 25);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
